mod_counter: RTL and testbench

Parametrised modulo up/down counter with runtime limit, variable step, wrap or saturate mode, synchronous load and overflow flags. It is the general-purpose successor to the fixed 32-bit free-running counter. Typical uses are timers, address generators and rate dividers alongside the adder datapath. Its arithmetic is done at WIDTH+1 bits so that carries and borrows are detected exactly.

---
 rtl/mod_counter.sv | 124 ++++++++++++
 tb/tb_mod_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Modulo up/down counter with a runtime inclusive limit (max_val), a variable
// step, wrap or saturate behaviour, a synchronous load and overflow flags.
// All range arithmetic is done one bit wider than the count so that carries,
// borrows and max_val+1 are represented exactly.
//
// Parameters
//   WIDTH      counter / limit / step / load width (2..64)
//   RESET_VAL  value of q after reset (must fit in WIDTH bits)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   en        in   apply one step this cycle
//   up        in   1 = count up, 0 = count down
//   mode      in   0 = wrap modulo max_val+1, 1 = saturate
//   step      in   amount per enabled cycle (0 = hold)
//   max_val   in   inclusive upper bound of the range 0..max_val
//   load      in   synchronous load strobe (q <= min(load_val, max_val))
//   load_val  in   value to load
//   clr_ovf   in   clear the sticky overflow flag (a same-cycle event wins)
//   q         out  current count (registered)
//   tc        out  one-cycle pulse alongside a q produced by wrap/saturation
//   ovf       out  sticky flag, set by any wrap/saturation event
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  typedef logic [WIDTH:0] ext_t;

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, ovf_q;
  logic             evt;

  // Widened operands; lim_ext = max_val+1 cannot truncate at max_val = 2^WIDTH-1.
  ext_t q_ext, step_ext, max_ext, lim_ext, sum_ext, def_ext;
  logic [WIDTH-1:0] wrap_up, rem_dn, wrap_dn, load_clamped;

  assign q_ext    = {1'b0, q_q};
  assign step_ext = {1'b0, step};
  assign max_ext  = {1'b0, max_val};
  assign lim_ext  = max_ext + ext_t'(1);
  assign sum_ext  = q_ext + step_ext;
  // Only meaningful when step > q; the borrow is then how far below zero we went.
  assign def_ext  = step_ext - q_ext;

  // Up-wrap: overshoot beyond the range, folded back into 0..max_val.
  // The remainder is < lim_ext <= 2^WIDTH, so it always fits in WIDTH bits.
  assign wrap_up = WIDTH'((sum_ext - lim_ext) % lim_ext);
  // Down-wrap: (q - step) mod (max_val+1), built from the borrow so that no
  // intermediate value goes negative even for steps larger than the range.
  assign rem_dn  = WIDTH'(def_ext % lim_ext);
  assign wrap_dn = (rem_dn == '0) ? '0 : WIDTH'(lim_ext - {1'b0, rem_dn});

  assign load_clamped = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else tree can leave a value unassigned and infer a latch.
    q_d = q_q;
    evt = 1'b0;
    if (load) begin
      q_d = load_clamped;
    end else if (en && (step != '0)) begin
      if (q_q > max_val) begin
        // Count left outside a range that was lowered at runtime.
        evt = 1'b1;
        q_d = mode ? max_val : '0;
      end else if (up) begin
        if (sum_ext <= max_ext) begin
          q_d = WIDTH'(sum_ext);
        end else begin
          evt = 1'b1;
          q_d = mode ? max_val : wrap_up;
        end
      end else begin
        if (step <= q_q) begin
          q_d = q_q - step;
        end else begin
          evt = 1'b1;
          q_d = mode ? '0 : wrap_dn;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= evt;
      // Set has priority over clear.
      ovf_q <= evt | (ovf_q & ~clr_ovf);
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//
// Drives two counters (WIDTH=8 with RESET_VAL=3, and WIDTH=32 with
// RESET_VAL=0) through directed scenarios and a randomized phase, comparing
// q, tc and ovf every cycle against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       a_reset, a_en, a_up, a_mode, a_load, a_clr;
  logic [7:0] a_step, a_max, a_lval, a_q;
  logic       a_tc, a_ovf;
  // 32-bit instance
  logic        b_reset, b_en, b_up, b_mode, b_load, b_clr;
  logic [31:0] b_step, b_max, b_lval, b_q;
  logic        b_tc, b_ovf;

  mod_counter #(.WIDTH(8), .RESET_VAL(8'd3)) dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .up(a_up), .mode(a_mode),
    .step(a_step), .max_val(a_max), .load(a_load), .load_val(a_lval),
    .clr_ovf(a_clr), .q(a_q), .tc(a_tc), .ovf(a_ovf)
  );

  mod_counter #(.WIDTH(32)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .mode(b_mode),
    .step(b_step), .max_val(b_max), .load(b_load), .load_val(b_lval),
    .clr_ovf(b_clr), .q(b_q), .tc(b_tc), .ovf(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  longint unsigned ma_q, mb_q;
  bit              ma_tc, ma_ovf, mb_tc, mb_ovf;

  // One enabled step computed with true modular arithmetic on wide integers.
  function automatic longint unsigned ref_step(input longint unsigned q, input longint unsigned stp,
                                               input longint unsigned maxv, input bit up, input bit mode,
                                               output bit evt);
    longint unsigned lim;
    lim = maxv + 1;
    evt = 1'b0;
    if (stp == 0) return q;
    if (q > maxv) begin
      evt = 1'b1;
      return mode ? maxv : 0;
    end
    if (up) begin
      if (q + stp <= maxv) return q + stp;
      evt = 1'b1;
      return mode ? maxv : (q + stp) % lim;
    end
    if (stp <= q) return q - stp;
    evt = 1'b1;
    return mode ? 0 : (lim - ((stp - q) % lim)) % lim;
  endfunction

  function automatic void ref_cycle(input bit rst, input bit ld, input bit en, input bit up,
                                    input bit mode, input bit clr, input longint unsigned rv,
                                    input longint unsigned lval, input longint unsigned stp,
                                    input longint unsigned maxv,
                                    inout longint unsigned q, inout bit tc, inout bit ovf);
    bit evt;
    evt = 1'b0;
    if (rst) begin
      q = rv; tc = 1'b0; ovf = 1'b0;
      return;
    end
    if (ld) q = (lval < maxv) ? lval : maxv;
    else if (en) q = ref_step(q, stp, maxv, up, mode, evt);
    tc  = evt;
    ovf = evt | (ovf & ~clr);
  endfunction

  // Advance both models with the current inputs, clock once, compare all outputs.
  task automatic cycle();
    ref_cycle(a_reset, a_load, a_en, a_up, a_mode, a_clr, 3, a_lval, a_step, a_max, ma_q, ma_tc, ma_ovf);
    ref_cycle(b_reset, b_load, b_en, b_up, b_mode, b_clr, 0, b_lval, b_step, b_max, mb_q, mb_tc, mb_ovf);
    @(posedge clk);
    #1;
    check("a_q", a_q, ma_q);
    check("a_tc", a_tc, ma_tc);
    check("a_ovf", a_ovf, ma_ovf);
    check("b_q", b_q, mb_q);
    check("b_tc", b_tc, mb_tc);
    check("b_ovf", b_ovf, mb_ovf);
  endtask

  task automatic idle_a();
    a_reset = 0; a_en = 0; a_load = 0; a_clr = 0;
  endtask

  task automatic idle_b();
    b_reset = 0; b_en = 0; b_load = 0; b_clr = 0;
  endtask

  task automatic load_a(input logic [7:0] v);
    idle_a(); a_load = 1; a_lval = v;
    cycle();
    a_load = 0;
  endtask

  task automatic load_b(input logic [31:0] v);
    idle_b(); b_load = 1; b_lval = v;
    cycle();
    b_load = 0;
  endtask

  initial begin
    // ---------------- reset, with load and en also asserted ----------------
    a_reset = 1; a_en = 1; a_load = 1; a_clr = 0; a_up = 1; a_mode = 0;
    a_step = 8'd1; a_max = 8'd200; a_lval = 8'd77;
    b_reset = 1; b_en = 1; b_load = 0; b_clr = 0; b_up = 1; b_mode = 0;
    b_step = 32'd1; b_max = 32'hFFFF_FFFF; b_lval = 32'd0;
    cycle();
    cycle();
    check("rst_q", a_q, 64'd3);
    check("rst_tc", a_tc, 64'd0);
    check("rst_ovf", a_ovf, 64'd0);
    check("rst_b_q", b_q, 64'd0);
    a_reset = 0; a_load = 0; b_reset = 0; b_en = 0;
    cycle();
    check("post_rst_q", a_q, 64'd4);

    // ---------------- up wrap, max_val=9 ----------------
    a_max = 8'd9; a_mode = 0; a_up = 1; a_step = 8'd1;
    load_a(8'd0);
    a_en = 1;
    for (int i = 0; i < 10; i++) cycle();
    check("upwrap_q", a_q, 64'd0);
    check("upwrap_tc", a_tc, 64'd1);
    a_en = 0;
    cycle();
    check("upwrap_ovf_sticky", a_ovf, 64'd1);
    check("upwrap_tc_drop", a_tc, 64'd0);

    // ---------------- down saturate ----------------
    a_max = 8'd9; a_mode = 1; a_up = 0; a_step = 8'd2;
    load_a(8'd5);
    a_en = 1;
    cycle(); cycle(); cycle();
    check("dnsat_q0", a_q, 64'd0);
    check("dnsat_tc0", a_tc, 64'd1);
    cycle();
    check("dnsat_tc_again", a_tc, 64'd1);
    a_en = 0; a_clr = 1;
    cycle();
    check("clr_ovf", a_ovf, 64'd0);
    a_clr = 0;

    // ---------------- multi-step wrap ----------------
    a_max = 8'd99; a_mode = 0; a_up = 1; a_step = 8'd10;
    load_a(8'd95);
    a_en = 1;
    cycle();
    check("mstep_up_q", a_q, 64'd5);
    check("mstep_up_tc", a_tc, 64'd1);
    a_up = 0;
    cycle();
    check("mstep_dn_q", a_q, 64'd95);
    check("mstep_dn_tc", a_tc, 64'd1);

    // ---------------- load clamp / priority / lowered max ----------------
    a_max = 8'd150; a_en = 1; a_load = 1; a_lval = 8'd200; a_up = 1; a_step = 8'd1;
    cycle();
    check("clamp_q", a_q, 64'd150);
    check("clamp_tc", a_tc, 64'd0);
    a_load = 0; a_max = 8'd100; a_clr = 1;
    cycle();
    check("lowered_q", a_q, 64'd0);
    check("lowered_tc", a_tc, 64'd1);
    check("set_beats_clr", a_ovf, 64'd1);
    a_clr = 0;

    // ---------------- max_val = 0 ----------------
    a_max = 8'd0; a_step = 8'd5; a_up = 1;
    cycle();
    check("max0_q", a_q, 64'd0);
    check("max0_tc", a_tc, 64'd1);

    // ---------------- reset mid-count ----------------
    a_max = 8'd200; a_step = 8'd7; a_reset = 1;
    cycle();
    check("midrst_q", a_q, 64'd3);
    a_reset = 0;
    cycle();
    check("midrst_resume", a_q, 64'd10);
    idle_a();

    // ---------------- full range, 32 bits ----------------
    b_max = 32'hFFFF_FFFF; b_up = 1; b_step = 32'd3; b_mode = 0;
    load_b(32'hFFFF_FFFE);
    b_en = 1;
    cycle();
    check("full_wrap_q", b_q, 64'd1);
    check("full_wrap_tc", b_tc, 64'd1);
    b_mode = 1;
    load_b(32'hFFFF_FFFE);
    b_en = 1;
    cycle();
    check("full_sat_q", b_q, 64'hFFFF_FFFF);
    check("full_sat_tc", b_tc, 64'd1);
    idle_b();

    // ---------------- randomized phase ----------------
    for (int i = 0; i < 3000; i++) begin
      a_reset = ($urandom_range(63) == 0);
      a_load  = ($urandom_range(7) == 0);
      a_en    = ($urandom_range(3) != 0);
      a_clr   = ($urandom_range(7) == 0);
      a_up    = $urandom_range(1);
      a_mode  = $urandom_range(1);
      if ($urandom_range(7) == 0) a_max = 8'($urandom());
      a_lval  = 8'($urandom());
      if (a_max == 8'hFF) a_step = 8'($urandom());
      else                a_step = 8'($urandom_range(int'(a_max) + 1));

      b_reset = ($urandom_range(63) == 0);
      b_load  = ($urandom_range(7) == 0);
      b_en    = ($urandom_range(3) != 0);
      b_clr   = ($urandom_range(7) == 0);
      b_up    = $urandom_range(1);
      b_mode  = $urandom_range(1);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       b_max = 32'hFFFF_FFFF;
          1:       b_max = 32'($urandom_range(15));
          default: b_max = $urandom();
        endcase
      end
      b_lval = ($urandom_range(1) == 0) ? $urandom() : (b_max - 32'($urandom_range(3)));
      if (b_max == 32'hFFFF_FFFF) b_step = $urandom();
      else b_step = 32'(({32'd0, $urandom()}) % (longint'(b_max) + 2));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
